// File: rtl/mult_accumulate_pkg.sv
// Shared definitions for the pipelined multiply-accumulate: FSM encoding,
// ceiling-log2 helper and default width constants.
package mult_accumulate_pkg;

   localparam int unsigned DEF_N     = 4;
   localparam int unsigned DEF_DW    = 8;
   localparam int unsigned DEF_AW    = 24;
   localparam int unsigned DEF_FRAME = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      int unsigned x;
      r = 0;
      x = (v > 1) ? v - 1 : 0;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mult_accumulate_tree.sv
// Stages S1-S2: registered per-pair unsigned products, then registered
// adder-tree sum of all N products, each stage with its own valid bit.
module mult_accumulate_tree
   import mult_accumulate_pkg::*;
#(
   parameter int unsigned N  = DEF_N,
   parameter int unsigned DW = DEF_DW
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          flush,
   input  logic [2*DW*N-1:0]             in_data,
   input  logic                          in_valid,
   output logic                          prod_valid,
   output logic [2*DW+clog2(N)-1:0]      sum,
   output logic                          sum_valid
);

   localparam int unsigned PW = 2 * DW;
   localparam int unsigned SW = PW + clog2(N);

   logic [PW-1:0] prod [N];
   logic [SW-1:0] tree_sum;

   always_comb begin
      tree_sum = '0;
      for (int unsigned k = 0; k < N; k++) begin
         tree_sum = tree_sum + SW'(prod[k]);
      end
   end

   // Datapath registers carry no reset; only the valids qualify them.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int unsigned k = 0; k < N; k++) begin
            prod[k] <= PW'(in_data[2*DW*k +: DW]) * PW'(in_data[2*DW*k+DW +: DW]);
         end
         sum <= tree_sum;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prod_valid <= 1'b0;
         sum_valid  <= 1'b0;
      end else if (en) begin
         prod_valid <= in_valid && !flush;
         sum_valid  <= prod_valid && !flush;
      end
   end

endmodule

// File: rtl/mult_accumulate_pipe.sv
// Pipelined frame multiply-accumulate with valid/ready on both sides.
// Define MULT_ACC_SATURATE_EN to clamp at 2^AW-1 instead of wrapping.
module mult_accumulate_pipe
   import mult_accumulate_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned DW    = DEF_DW,
   parameter int unsigned AW    = DEF_AW,
   parameter int unsigned FRAME = DEF_FRAME
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [2*DW*N-1:0]   In,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                clr,
   output logic [AW-1:0]       Out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                ovf
);

   localparam int unsigned SW = 2 * DW + clog2(N);
   localparam int unsigned CW = (FRAME > 1) ? clog2(FRAME) : 1;

   logic          stall;
   logic          beat;
   logic          flush;
   logic          v1;
   logic          v2;
   logic [SW-1:0] sum;
   logic [AW-1:0] acc;
   logic [CW-1:0] cnt;
   logic          fovf;
   logic [AW:0]   acc_sum;
   logic          carry;
   logic [AW-1:0] acc_add;
   logic          frame_ovf;
   logic          last;
   logic          busy_nxt;
   state_t        state;

   assign stall    = out_valid && !out_ready;
   assign in_ready = !rst && !stall && !clr;
   assign beat     = in_valid && in_ready;
   assign flush    = clr && !stall;

   mult_accumulate_tree #(.N(N), .DW(DW)) u_tree (
      .clk        (clk),
      .rst        (rst),
      .en         (!stall),
      .flush      (flush),
      .in_data    (In),
      .in_valid   (beat),
      .prod_valid (v1),
      .sum        (sum),
      .sum_valid  (v2)
   );

   always_comb begin
      acc_sum   = {1'b0, acc} + (AW+1)'(sum);
      carry     = acc_sum[AW];
`ifdef MULT_ACC_SATURATE_EN
      acc_add   = carry ? {AW{1'b1}} : acc_sum[AW-1:0];
`else
      acc_add   = acc_sum[AW-1:0];
`endif
      frame_ovf = fovf | carry;
      last      = (cnt == CW'(FRAME - 1));
      busy_nxt  = beat || v1 || (v2 ? !last : (cnt != '0));
   end

   // S3: accumulate, deliver a result on the last beat of each frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         fovf      <= 1'b0;
         Out       <= '0;
         out_valid <= 1'b0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         if (clr) begin
            acc  <= '0;
            cnt  <= '0;
            fovf <= 1'b0;
         end else if (v2) begin
            if (last) begin
               Out  <= acc_add;
               ovf  <= frame_ovf;
               acc  <= '0;
               cnt  <= '0;
               fovf <= 1'b0;
            end else begin
               acc  <= acc_add;
               cnt  <= cnt + CW'(1);
               fovf <= frame_ovf;
            end
         end
         if (!clr && v2 && last) begin
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

   // Pipeline occupancy tracker; HOLD defers a clear until the stall ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE:    if (beat) state <= RUN;
            RUN: begin
               if (stall)          state <= HOLD;
               else if (flush)     state <= IDLE;
               else if (!busy_nxt) state <= IDLE;
            end
            HOLD:    if (!stall) state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_accumulate_pipe.sv
// Directed bench for mult_accumulate_pipe: three instances (FRAME=1,
// FRAME=2, AW=16/FRAME=2) share stimulus; expected values are hand-computed.
module tb_mult_accumulate_pipe;

   localparam int unsigned N  = 4;
   localparam int unsigned DW = 8;

   // Pairs (a,b) packed as {b,a} per 16 bits, pair 0 in the low bits.
   localparam logic [63:0] B1 = 64'h02AB_0603_02AB_0603; // sum 0x0002D0
   localparam logic [63:0] B2 = 64'h02AB_0603_0508_FFFF; // sum 0x00FF91
   localparam logic [63:0] B3 = 64'h0101_0101_0101_0101; // sum 0x000004

   logic        clk;
   logic        rst;
   logic [63:0] in_data;
   logic        in_valid;
   logic        clr;
   logic        out_ready;

   logic [23:0] out_f1, out_f2;
   logic [15:0] out_a16;
   logic        ov_f1, ov_f2, ov_a16;
   logic        of_f1, of_f2, of_a16;
   logic        rdy_f1, rdy_f2, rdy_a16;

   int checks   = 0;
   int failures = 0;

   mult_accumulate_pipe #(.N(N), .DW(DW), .AW(24), .FRAME(1)) u_f1 (
      .clk(clk), .rst(rst), .In(in_data), .in_valid(in_valid), .in_ready(rdy_f1),
      .clr(clr), .Out(out_f1), .out_valid(ov_f1), .out_ready(out_ready), .ovf(of_f1)
   );

   mult_accumulate_pipe #(.N(N), .DW(DW), .AW(24), .FRAME(2)) u_f2 (
      .clk(clk), .rst(rst), .In(in_data), .in_valid(in_valid), .in_ready(rdy_f2),
      .clr(clr), .Out(out_f2), .out_valid(ov_f2), .out_ready(out_ready), .ovf(of_f2)
   );

   mult_accumulate_pipe #(.N(N), .DW(DW), .AW(16), .FRAME(2)) u_a16 (
      .clk(clk), .rst(rst), .In(in_data), .in_valid(in_valid), .in_ready(rdy_a16),
      .clr(clr), .Out(out_a16), .out_valid(ov_a16), .out_ready(out_ready), .ovf(of_a16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      clr       = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready",  32'(rdy_f1), 32'h0);
      check("rst_out",       32'(out_f1), 32'h0);
      check("rst_out_valid", 32'(ov_f1),  32'h0);
      check("rst_ovf",       32'(of_f1),  32'h0);
      rst = 1'b0;
      tick();
      check("rel_in_ready",  32'(rdy_f1), 32'h1);

      // Two reference beats back to back.
      in_data = B1; in_valid = 1'b1;
      tick();
      in_data = B2;
      tick();
      in_valid = 1'b0;
      tick();
      check("f1_beat1_out",   32'(out_f1), 32'h0002D0);
      check("f1_beat1_valid", 32'(ov_f1),  32'h1);
      check("f2_mid_valid",   32'(ov_f2),  32'h0);
      tick();
      check("f1_beat2_out",   32'(out_f1), 32'h00FF91);
      check("f1_beat2_valid", 32'(ov_f1),  32'h1);
      check("f2_frame_out",   32'(out_f2), 32'h010261);
      check("f2_frame_valid", 32'(ov_f2),  32'h1);
      check("f2_frame_ovf",   32'(of_f2),  32'h0);
`ifdef MULT_ACC_SATURATE_EN
      check("a16_out_sat",    32'(out_a16), 32'hFFFF);
`else
      check("a16_out_wrap",   32'(out_a16), 32'h0261);
`endif
      check("a16_ovf",        32'(of_a16), 32'h1);
      tick();
      check("f1_drain_valid", 32'(ov_f1),  32'h0);

      // Backpressure: stall after the first result, then resume.
      do_reset();
      in_data = B1; in_valid = 1'b1;
      tick();
      in_data = B3;
      tick();
      in_data = B2;
      tick();
      check("bp_first_out", 32'(out_f1), 32'h0002D0);
      out_ready = 1'b0;
      in_data   = B1;
      #1;
      check("bp_ready_low", 32'(rdy_f1), 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_hold_ready", 32'(rdy_f1), 32'h0);
         check("bp_hold_out",   32'(out_f1), 32'h0002D0);
         check("bp_hold_valid", 32'(ov_f1),  32'h1);
      end
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("bp_res2_out",   32'(out_f1), 32'h000004);
      check("bp_res2_valid", 32'(ov_f1),  32'h1);
      tick();
      check("bp_res3_out",   32'(out_f1), 32'h00FF91);
      tick();
      check("bp_res4_out",   32'(out_f1), 32'h0002D0);
      check("bp_res4_valid", 32'(ov_f1),  32'h1);
      tick();
      check("bp_end_valid",  32'(ov_f1),  32'h0);

      // Clear aborts a half-accumulated frame and drops the beat offered with it.
      do_reset();
      in_data = B3; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      clr = 1'b1; in_data = B2; in_valid = 1'b1;
      #1;
      check("clr_in_ready", 32'(rdy_f2), 32'h0);
      tick();
      clr = 1'b0; in_data = B1;
      tick();
      in_data = B2;
      tick();
      in_data = B3;
      tick();
      in_valid = 1'b0;
      check("clr_mid_valid", 32'(ov_f2), 32'h0);
      tick();
      check("clr_frame_out",   32'(out_f2), 32'h010261);
      check("clr_frame_valid", 32'(ov_f2),  32'h1);
      check("clr_frame_ovf",   32'(of_f2),  32'h0);
      tick();
      check("f1_mid_out", 32'(out_f1), 32'h000004);

      // Asynchronous reset mid-frame (f2 holds one beat of B3).
      #2;
      rst = 1'b1;
      #1;
      check("arst_f2_out",   32'(out_f2), 32'h0);
      check("arst_f2_valid", 32'(ov_f2),  32'h0);
      check("arst_f1_out",   32'(out_f1), 32'h0);
      check("arst_f1_valid", 32'(ov_f1),  32'h0);
      check("arst_a16_ovf",  32'(of_a16), 32'h0);
      check("arst_ready",    32'(rdy_f2), 32'h0);
      tick();
      rst = 1'b0;
      in_data = B2; in_valid = 1'b1;
      tick();
      in_data = B1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      check("post_rst_out",   32'(out_f2), 32'h010261);
      check("post_rst_valid", 32'(ov_f2),  32'h1);
      check("post_rst_a16_ovf", 32'(of_a16), 32'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
